// File: rtl/req_onehot_arbiter.sv
// req_onehot_arbiter
// Upstream stage of the 8-to-3 encoder. Turns rising edges on eight request
// lines into held pending requests, then issues them one at a time in
// round-robin order as a clean one-hot grant with an enable strobe. Every
// grant waits for an ack from the consumer before the next one is issued.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no grant presented; out_en=0, out_onehot=0
// GRANT  | out_onehot/out_en held stable until ack is sampled high
//
module req_onehot_arbiter #(
    parameter int SYNC_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [7:0] out_onehot,
    output logic       out_en,
    output logic [7:0] pending,
    output logic [7:0] ovf_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // synchronized request lines
    logic [7:0] s2;

    // edge detect, pending and overflow state
    logic [7:0] prev_q, prev_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // grant FSM state
    state_t     state_q, state_d;
    logic [7:0] out_onehot_q, out_onehot_d;
    logic       out_en_q, out_en_d;
    logic [2:0] gidx_q, gidx_d;
    logic [2:0] ptr_q, ptr_d;

    // combinational helpers
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] lost;
    logic [3:0] lost_cnt;
    logic [8:0] ovf_sum;
    logic [7:0] rot;
    logic [2:0] pick_off;
    logic [2:0] pick_idx;

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [7:0] s1_q, s1_d;
            logic [7:0] s2_q, s2_d;

            // two-flop synchronizer stage inputs
            always_comb begin
                s1_d = req;
                s2_d = s1_q;
            end

            // synchronizer flops, cleared by reset so a line held high
            // across reset release produces exactly one rise
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_q <= 8'h00;
                    s2_q <= 8'h00;
                end else begin
                    s1_q <= s1_d;
                    s2_q <= s2_d;
                end
            end

            assign s2 = s2_q;
        end else begin : g_nosync
            assign s2 = req;
        end
    endgenerate

    // edge detect, pending set/clear with set priority, saturating overflow
    always_comb begin
        rise      = s2 & ~prev_q;
        clr       = ((state_q == ST_GRANT) && ack) ? out_onehot_q : 8'h00;
        prev_d    = s2;
        pending_d = (pending_q & ~clr) | rise;
        lost      = rise & pending_q & ~clr;
        lost_cnt  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            lost_cnt = lost_cnt + {3'd0, lost[i]};
        end
        ovf_sum   = {1'b0, ovf_cnt_q} + {5'd0, lost_cnt};
        ovf_cnt_d = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end

    // round-robin pick: rotate pending so index ptr lands at bit 0, then
    // take the lowest set bit and map it back to an absolute index
    always_comb begin
        rot = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rot[i] = pending_q[ptr_q + 3'(i)];
        end
        pick_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                pick_off = 3'(i);
            end
        end
        pick_idx = ptr_q + pick_off;
    end

    // grant FSM next state; outputs are computed here and registered below
    always_comb begin
        state_d      = state_q;
        out_onehot_d = out_onehot_q;
        out_en_d     = out_en_q;
        gidx_d       = gidx_q;
        ptr_d        = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    state_d      = ST_GRANT;
                    out_onehot_d = 8'(1) << pick_idx;
                    out_en_d     = 1'b1;
                    gidx_d       = pick_idx;
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    state_d      = ST_IDLE;
                    out_onehot_d = 8'h00;
                    out_en_d     = 1'b0;
                    ptr_d        = gidx_q + 3'd1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                out_onehot_d = 8'h00;
                out_en_d     = 1'b0;
            end
        endcase
    end

    // request bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= 8'h00;
            pending_q <= 8'h00;
            ovf_cnt_q <= 8'h00;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // grant FSM registers, including the registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_onehot_q <= 8'h00;
            out_en_q     <= 1'b0;
            gidx_q       <= 3'd0;
            ptr_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            out_onehot_q <= out_onehot_d;
            out_en_q     <= out_en_d;
            gidx_q       <= gidx_d;
            ptr_q        <= ptr_d;
        end
    end

    assign out_onehot = out_onehot_q;
    assign out_en     = out_en_q;
    assign pending    = pending_q;
    assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: doc/req_onehot_arbiter.md
# req_onehot_arbiter

- Upstream stage of the 8-to-3 encoder.
- Captures rising edges on 8 asynchronous request lines and holds each as a pending request.
- Picks one pending request at a time by round-robin and presents it as a clean one-hot vector with an enable strobe, so the encoder only ever sees a single hot bit.
- The consumer acknowledges each grant before the next one is issued.

## Interface
Parameters:
- SYNC_EN, default 1: 1 = two-flop synchronizer on every request line; 0 = request lines used directly (already synchronous sources).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request lines; a 0→1 transition is one request event.
- ack  input  1  consumer accepts the current grant.
- out_onehot  output  8  registered one-hot grant; 8'h00 when no grant is active. Drives the encoder data input.
- out_en  output  1  registered; high while out_onehot holds a valid grant. Drives the encoder enable.
- pending  output  8  registered pending-request vector.
- ovf_cnt  output  8  saturating count of request events lost because that line was already pending.

## Operation
- Synchronizer, SYNC_EN=1: s1 <= req; s2 <= s1. With SYNC_EN=0, s2 is req itself.
- Edge detect: prev <= s2; rise = s2 & ~prev.
- Pending update each cycle: pending <= (pending & ~clr) | rise.
  - clr is the one-hot grant being acknowledged this cycle, else 0.
  - Set wins: a rise on the line being cleared in the same cycle leaves that bit set.
- Overflow:
  - ovf_cnt increments by the number of lines with rise & pending & ~clr set in the cycle.
  - Sum of 0..8 added; result saturates at 8'hFF.
  - A rise on a line being cleared in the same cycle is not an overflow.
- Pointer ptr, 3 bits, reset 0:
  - The grant search starts at index ptr, ascends, and wraps 7→0.
  - The first pending bit found is chosen.
- States:
  - IDLE (out_en=0): if pending != 0, at the next edge load out_onehot with the chosen bit, set out_en=1, go to GRANT. Otherwise stay.
  - GRANT (out_en=1):
    - out_onehot and out_en are held stable.
    - When ack=1 is sampled: out_en <= 0, out_onehot <= 0, clear that pending bit, ptr <= granted index + 1 (mod 8), go to IDLE.
- ack sampled while out_en=0 is ignored.
- ack may be held high permanently. Grants then complete at one per two cycles.
- out_onehot never has more than one bit set, and is 0 whenever out_en=0.

## Timing
- Reset, asynchronous: s1, s2, prev, pending, out_onehot, ovf_cnt = 0; out_en = 0; ptr = 0; state IDLE.
- A line held high through reset deassertion counts as one rise event.
- Latency from the first edge where req is sampled high to out_en high, with the block idle and no other pending:
  - 3 cycles with SYNC_EN=1.
  - 1 cycle with SYNC_EN=0.
- Pending becomes visible 1 cycle before out_en.
- Grant issue is based on the registered pending value of the current cycle.
- Throughput: minimum one IDLE cycle between consecutive grants, i.e. at most one grant per 2 cycles.
- Reset asserted mid-GRANT: all outputs drop to 0 immediately, no completion. A subsequent ack is ignored.

## Test plan
- Reset and single request:
  - Stimulus: rst pulse; SYNC_EN=1; req=8'h04 from cycle 0; ack held high.
  - Required: out_en=1 with out_onehot=8'h04 3 cycles after req is first sampled, then low the next cycle.
  - Required: pending returns to 8'h00; ptr=3; ovf_cnt=0.
- Round robin:
  - Stimulus: rising edges on req bits 1, 5 and 6 in one cycle; ack held high.
  - Required: grants in the order 8'h02, 8'h20, 8'h40, one every 2 cycles.
  - Then a new edge on bit 0 and bit 7 together → 8'h80 granted before 8'h01 (ptr=7).
- Hold without ack:
  - Stimulus: grant 8'h10 active, ack=0 for 10 cycles while bit 2 rises.
  - Required: out_onehot stays 8'h10 and out_en stays 1; pending=8'h14.
  - After ack, the next grant is 8'h04.
- Overflow and set-wins:
  - Stimulus: bit 3 pending and not granted; two more edges on bit 3 → ovf_cnt=2.
  - Stimulus: an edge on bit 3 in the same cycle its grant is acked.
  - Required: bit 3 stays pending, ovf_cnt unchanged, bit 3 is granted again.
  - Forcing 300 overflows → ovf_cnt=8'hFF.
- Async reset mid-grant:
  - Stimulus: assert rst between clock edges during GRANT.
  - Required: out_en, out_onehot, pending and ovf_cnt are 0 before the next clk edge.
  - Required: the first grant after release starts the search at bit 0.
- SYNC_EN=0: req bit 7 rises → out_onehot=8'h80 with out_en=1 one cycle after the sampling edge.
